fu_complete_arb: RTL and testbench

//  Completion stage directly downstream of the reservation station (RS).

---
 rtl/fu_complete_arb_pkg.sv | 37 +++
 rtl/fu_complete_arb_slot.sv | 57 +++++
 rtl/fu_complete_arb.sv | 86 ++++++++
 tb/tb_fu_complete_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_complete_arb_pkg.sv
// Shared types for the completion/CDB stage and the reservation station that
// consumes its broadcasts.
package fu_complete_arb_pkg;

   localparam int NUM_FU   = 5;
   localparam int PR_W     = 6;
   localparam int LAT_W    = 3;
   localparam int FU_IDX_W = $clog2(NUM_FU);

   typedef enum logic [2:0] {
      FU_ALU0,
      FU_ALU1,
      FU_MUL,
      FU_LSU,
      FU_BR
   } FU_t;

   // Slot i of the completion stage serves FU_LIST[i]
   localparam FU_t FU_LIST [NUM_FU] = '{FU_ALU0, FU_ALU1, FU_MUL, FU_LSU, FU_BR};

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_EXEC,
      SLOT_DONE
   } SLOT_STATE_t;

   typedef struct packed {
      logic            complete_en;
      logic [PR_W-1:0] CDB_T;
   } CDB_PACKET;

   // A programmed latency of 0 behaves as a single-cycle unit
   function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
      return (lat == '0) ? LAT_W'(1) : lat;
   endfunction

endpackage

// File: rtl/fu_complete_arb_slot.sv
// One FU execution slot: holds the destination tag while the FU's latency
// elapses, then requests the CDB until granted.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  SLOT_IDLE | empty, can accept an issue
//  SLOT_EXEC | tag latched, cnt counts remaining cycles down to 0
//  SLOT_DONE | result ready, requesting the CDB until granted
module fu_slot
   import fu_complete_arb_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              issue,
   input  logic [PR_W-1:0]   issue_T,
   input  logic [LAT_W-1:0]  lat,
   input  logic              grant,
   output SLOT_STATE_t       state,
   output logic [PR_W-1:0]   T
);

   logic [LAT_W-1:0] cnt;
   logic [LAT_W-1:0] lat_eff;

   assign lat_eff = eff_lat(lat);

   // Slot FSM. Every issue passes through EXEC (a 1-cycle op loads cnt=0), so
   // the slot becomes DONE exactly L edges after the issue edge for any L.
   // An issue on the grant edge reloads the slot in place of returning to IDLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= SLOT_IDLE;
         cnt   <= '0;
         T     <= '0;
      end else if (flush) begin
         state <= SLOT_IDLE;
         cnt   <= '0;
      end else if (issue) begin
         state <= SLOT_EXEC;
         cnt   <= lat_eff - LAT_W'(1);
         T     <= issue_T;
      end else begin
         case (state)
            SLOT_EXEC: begin
               if (cnt == '0) state <= SLOT_DONE;
               else           cnt   <= cnt - LAT_W'(1);
            end
            SLOT_DONE: begin
               if (grant) state <= SLOT_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fu_complete_arb.sv
// Completion stage behind the reservation station: per-FU latency slots plus
// a round-robin arbiter that drives one registered CDB broadcast per cycle.
module fu_complete_arb
   import fu_complete_arb_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        issue_valid,
   input  logic [NUM_FU*PR_W-1:0]   issue_T,
   input  logic [NUM_FU*LAT_W-1:0]  fu_lat,
   output logic [NUM_FU-1:0]        fu_ready,
   output logic                     complete_en,
   output logic [PR_W-1:0]          CDB_T,
   output logic [FU_IDX_W-1:0]      cdb_fu
);

   SLOT_STATE_t         slot_state [NUM_FU];
   logic [PR_W-1:0]     slot_T     [NUM_FU];
   logic [NUM_FU-1:0]   req;
   logic [NUM_FU-1:0]   grant;
   logic [NUM_FU-1:0]   issue_acc;
   logic                gnt_any;
   logic [FU_IDX_W-1:0] gnt_idx;
   logic [FU_IDX_W-1:0] rr_ptr;
   CDB_PACKET           cdb_q;
   logic [FU_IDX_W-1:0] cdb_fu_q;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
      fu_slot u_slot (
         .clock   (clock),
         .reset   (reset),
         .flush   (flush),
         .issue   (issue_acc[i]),
         .issue_T (issue_T[i*PR_W +: PR_W]),
         .lat     (fu_lat[i*LAT_W +: LAT_W]),
         .grant   (grant[i]),
         .state   (slot_state[i]),
         .T       (slot_T[i])
      );

      assign req[i]       = (slot_state[i] == SLOT_DONE);
      // A DONE slot being granted this cycle frees up on the same edge
      assign fu_ready[i]  = !flush && ((slot_state[i] == SLOT_IDLE) || (req[i] && grant[i]));
      assign issue_acc[i] = issue_valid[i] && fu_ready[i];
   end

   // Round-robin pick: first requesting slot at or after rr_ptr, wrapping
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int off = 0; off < NUM_FU; off++) begin
         idx = (int'(rr_ptr) + off) % NUM_FU;
         if (!gnt_any && req[idx]) begin
            gnt_any    = 1'b1;
            gnt_idx    = FU_IDX_W'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   // CDB registers and pointer update; flush discards this cycle's grant
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr   <= '0;
         cdb_q    <= '0;
         cdb_fu_q <= '0;
      end else if (flush) begin
         cdb_q.complete_en <= 1'b0;
      end else if (gnt_any) begin
         cdb_q    <= '{complete_en: 1'b1, CDB_T: slot_T[gnt_idx]};
         cdb_fu_q <= gnt_idx;
         rr_ptr   <= (gnt_idx == FU_IDX_W'(NUM_FU-1)) ? '0 : gnt_idx + FU_IDX_W'(1);
      end else begin
         cdb_q.complete_en <= 1'b0;
      end
   end

   assign complete_en = cdb_q.complete_en;
   assign CDB_T       = cdb_q.CDB_T;
   assign cdb_fu      = cdb_fu_q;

endmodule

// File: tb/tb_fu_complete_arb.sv
// Bench for fu_complete_arb: a cycle-level reference model (pending tag per FU
// with the cycle it becomes ready) pushes expected broadcasts into a
// scoreboard; a separate monitor pops them whenever complete_en is seen.
module tb_fu_complete_arb;
   import fu_complete_arb_pkg::*;

   localparam int N = NUM_FU;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    flush;
   logic [N-1:0]            issue_valid;
   logic [N*PR_W-1:0]       issue_T;
   logic [N*LAT_W-1:0]      fu_lat;
   logic [N-1:0]            fu_ready;
   logic                    complete_en;
   logic [PR_W-1:0]         CDB_T;
   logic [FU_IDX_W-1:0]     cdb_fu;

   fu_complete_arb dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_T     (issue_T),
      .fu_lat      (fu_lat),
      .fu_ready    (fu_ready),
      .complete_en (complete_en),
      .CDB_T       (CDB_T),
      .cdb_fu      (cdb_fu)
   );

   always #5 clock = ~clock;

   typedef struct {
      int tag;
      int fu;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // reference model: one pending tag per FU and the cycle it starts requesting
   bit   m_busy [N];
   int   m_tag  [N];
   int   m_rdy  [N];
   int   m_ptr;
   int   lat_cfg [N];

   bit   want_v [N];
   int   want_T [N];
   bit   want_flush;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0;
         m_tag[i]  = 0;
         m_rdy[i]  = 0;
      end
      m_ptr = 0;
   endtask

   task automatic clear_want();
      for (int i = 0; i < N; i++) begin
         want_v[i] = 1'b0;
         want_T[i] = 0;
      end
      want_flush = 1'b0;
   endtask

   // one clock cycle; called just after a falling edge
   task automatic step();
      int           g;
      logic [N-1:0] mr;
      g = -1;
      for (int o = 0; o < N; o++) begin
         int i;
         i = (m_ptr + o) % N;
         if (g < 0 && m_busy[i] && m_rdy[i] <= cyc) g = i;
      end
      for (int i = 0; i < N; i++) begin
         mr[i]                     = !want_flush && (!m_busy[i] || i == g);
         issue_valid[i]            = want_v[i] && mr[i];
         issue_T[i*PR_W +: PR_W]   = PR_W'(want_T[i]);
         fu_lat[i*LAT_W +: LAT_W]  = LAT_W'(lat_cfg[i]);
      end
      flush = want_flush;
      #1;
      chk("fu_ready", int'(fu_ready), int'(mr));
      for (int i = 0; i < N; i++) begin
         assert (!(issue_valid[i] && !fu_ready[i]))
         else begin
            errors++;
            $display("FAIL issue_while_not_ready: fu %0d valid=1 ready=0 (cycle %0d)", i, cyc);
         end
      end
      @(posedge clock);
      cyc++;
      if (want_flush) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      end else begin
         if (g >= 0) begin
            sb.push_back('{tag: m_tag[g], fu: g, cyc: cyc});
            m_busy[g] = 1'b0;
            m_ptr     = (g + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (issue_valid[i]) begin
               m_busy[i] = 1'b1;
               m_tag[i]  = want_T[i];
               m_rdy[i]  = cyc + ((lat_cfg[i] == 0) ? 1 : lat_cfg[i]);
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      clear_want();
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic issue1(input int a, input int ta);
      clear_want();
      want_v[a] = 1'b1;
      want_T[a] = ta;
      step();
      clear_want();
   endtask

   task automatic issue2(input int a, input int ta, input int b, input int tb);
      clear_want();
      want_v[a] = 1'b1;
      want_T[a] = ta;
      want_v[b] = 1'b1;
      want_T[b] = tb;
      step();
      clear_want();
   endtask

   // monitor: compare each broadcast with the oldest expected one
   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b1) begin
         if (complete_en === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cdb_unexpected: got T=%0d fu=%0d, expected no broadcast (cycle %0d)",
                        CDB_T, cdb_fu, cyc);
            end else begin
               e = sb.pop_front();
               chk("cdb_T", int'(CDB_T), e.tag);
               chk("cdb_fu", int'(cdb_fu), e.fu);
               chk("cdb_cycle", cyc, e.cyc);
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL cdb_missing: got complete_en=0, expected T=%0d fu=%0d (cycle %0d)",
                     e.tag, e.fu, cyc);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      issue_valid = '0;
      issue_T     = '0;
      fu_lat      = '0;
      lat_cfg     = '{1, 3, 1, 1, 4};
      model_clear();
      clear_want();

      // reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_complete_en", int'(complete_en), 0);
      chk("reset_CDB_T", int'(CDB_T), 0);
      chk("reset_cdb_fu", int'(cdb_fu), 0);
      reset = 1'b1;
      #1;
      chk("ready_after_reset", int'(fu_ready), 31);

      // single op, latency 3
      issue1(1, 12);
      idle(6);

      // contention between two single-cycle units, then a simultaneous pair
      issue2(0, 5, 2, 9);
      idle(4);
      issue2(0, 7, 2, 8);
      idle(4);

      // pass-through refill on the grant edge
      begin : t_pass
         clear_want();
         want_v[3] = 1'b1;
         want_T[3] = 20;
         step();
         want_T[3] = 21;
         for (int n = 0; n < 10 && !(m_busy[3] && m_tag[3] == 21); n++) step();
         idle(4);
      end

      // flush drops an in-flight tag
      issue1(4, 30);
      idle(1);
      clear_want();
      want_flush = 1'b1;
      step();
      idle(8);

      // async reset while a broadcast is up and another slot is DONE
      issue2(0, 40, 2, 41);
      idle(2);
      #2;
      chk("pre_reset_complete_en", int'(complete_en), 1);
      reset = 1'b0;
      #1;
      chk("async_reset_complete_en", int'(complete_en), 0);
      chk("async_reset_CDB_T", int'(CDB_T), 0);
      model_clear();
      issue_valid = '0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      idle(8);

      // randomized traffic with flushes and changing latencies
      for (int n = 0; n < 400; n++) begin
         if (n % 60 == 0)
            for (int i = 0; i < N; i++) lat_cfg[i] = int'($urandom_range(0, 7));
         for (int i = 0; i < N; i++) begin
            want_v[i] = ($urandom_range(0, 2) != 0);
            want_T[i] = int'($urandom_range(0, 63));
         end
         want_flush = ($urandom_range(0, 24) == 0);
         step();
      end
      idle(25);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
